// File: rtl/ysyx_24080014_lsu.sv
// Load/store unit: one outstanding op, word-aligned valid/ready bus,
// byte strobes, load extraction and a REQ/WAIT timeout.
module ysyx_24080014_lsu #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_ren,
  input  logic        in_wen,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [4:0]  in_rd,
  output logic        req_valid,
  input  logic        req_ready,
  output logic        req_wen,
  output logic [31:0] req_addr,
  output logic [31:0] req_wdata,
  output logic [3:0]  req_wstrb,
  input  logic        rsp_valid,
  output logic        rsp_ready,
  input  logic [31:0] rsp_rdata,
  input  logic        rsp_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_rd,
  output logic [31:0] out_rdata,
  output logic        out_regwr,
  output logic [1:0]  out_err
);

  localparam int CW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int TLIM =
    (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  typedef enum logic [1:0] {
    IDLE, REQ, WAIT, DONE
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic            op_wen;
  logic [2:0]      op_f3;
  logic [1:0]      op_off;
  logic [CW-1:0]   cnt;
  logic            acc;
  logic            bad;
  logic            misal;
  logic            tmo;
  logic [31:0]     st_wdata;
  logic [3:0]      st_wstrb;
  logic [31:0]     ld_word;
  logic [31:0]     ld_data;

  assign in_ready  = rst_n & (state == IDLE);
  assign req_valid = (state == REQ);
  assign rsp_ready = (state == WAIT);
  assign out_valid = (state == DONE);
  assign acc       = in_valid & in_ready;

  assign tmo = (TIMEOUT_CYCLES != 0) &&
               (cnt == CW'(TLIM));

  // Classify the incoming op: illegal encoding or misaligned access
  always_comb begin
    bad = 1'b0;
    if (in_ren == in_wen)
      bad = 1'b1;
    else if (in_ren)
      bad = !(in_funct3 inside
              {3'b000, 3'b001, 3'b010,
               3'b100, 3'b101});
    else
      bad = !(in_funct3 inside
              {3'b000, 3'b001, 3'b010});
    misal = ((in_funct3[1:0] == 2'b01) &
             in_addr[0]) |
            ((in_funct3[1:0] == 2'b10) &
             (|in_addr[1:0]));
  end

  // Replicate store data across lanes and build byte strobes
  always_comb begin
    st_wdata = in_wdata;
    st_wstrb = 4'b1111;
    unique case (in_funct3[1:0])
      2'b00: begin
        st_wdata = {4{in_wdata[7:0]}};
        st_wstrb = 4'b0001 << in_addr[1:0];
      end
      2'b01: begin
        st_wdata = {2{in_wdata[15:0]}};
        st_wstrb = 4'b0011 << in_addr[1:0];
      end
      default: begin
        st_wdata = in_wdata;
        st_wstrb = 4'b1111;
      end
    endcase
    if (!in_wen)
      st_wstrb = 4'b0000;
  end

  // Shift the addressed bytes down and extend to 32 bits
  always_comb begin
    ld_word = rsp_rdata >> {op_off, 3'b000};
    unique case (op_f3)
      3'b000:
        ld_data = {{24{ld_word[7]}}, ld_word[7:0]};
      3'b001:
        ld_data = {{16{ld_word[15]}}, ld_word[15:0]};
      3'b100:
        ld_data = {24'b0, ld_word[7:0]};
      3'b101:
        ld_data = {16'b0, ld_word[15:0]};
      default:
        ld_data = ld_word;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (acc)
          state_nx = (bad | misal) ? DONE : REQ;
      REQ:
        if (req_ready)
          state_nx = WAIT;
        else if (tmo)
          state_nx = DONE;
      WAIT:
        if (rsp_valid | tmo)
          state_nx = DONE;
      DONE:
        if (out_ready)
          state_nx = IDLE;
      default:
        state_nx = IDLE;
    endcase
  end

  // Op capture, bus request fields, result and timeout counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_wen    <= 1'b0;
      op_f3     <= 3'b0;
      op_off    <= 2'b0;
      cnt       <= '0;
      req_wen   <= 1'b0;
      req_addr  <= 32'b0;
      req_wdata <= 32'b0;
      req_wstrb <= 4'b0;
      out_rd    <= 5'b0;
      out_rdata <= 32'b0;
      out_regwr <= 1'b0;
      out_err   <= 2'b00;
    end else begin
      unique case (state)
        IDLE: if (acc) begin
          op_wen    <= in_wen;
          op_f3     <= in_funct3;
          op_off    <= in_addr[1:0];
          cnt       <= '0;
          req_wen   <= in_wen;
          req_addr  <= {in_addr[31:2], 2'b00};
          req_wdata <= st_wdata;
          req_wstrb <= st_wstrb;
          out_rd    <= in_rd;
          out_rdata <= 32'b0;
          out_regwr <= 1'b0;
          out_err   <= (bad | misal) ? 2'b01 : 2'b00;
        end
        REQ: if (!req_ready) begin
          cnt <= cnt + 1'b1;
          if (tmo)
            out_err <= 2'b11;
        end
        WAIT: if (rsp_valid) begin
          if (rsp_err)
            out_err <= 2'b10;
          else if (!op_wen) begin
            out_rdata <= ld_data;
            out_regwr <= 1'b1;
          end
        end else begin
          cnt <= cnt + 1'b1;
          if (tmo)
            out_err <= 2'b11;
        end
        DONE: if (out_ready)
          out_regwr <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_24080014_lsu.sv
// Randomized self-checking bench for ysyx_24080014_lsu.
// Drives/samples on negedge against a behavioural model.
module tb_ysyx_24080014_lsu;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_ren;
  logic        in_wen;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic [4:0]  in_rd;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_rd;
  logic [31:0] out_rdata;
  logic        out_regwr;
  logic [1:0]  out_err;

  int checks = 0;
  int errors = 0;

  ysyx_24080014_lsu #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ren(in_ren), .in_wen(in_wen),
    .in_funct3(in_funct3), .in_addr(in_addr),
    .in_wdata(in_wdata), .in_rd(in_rd),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_wen(req_wen), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rd(out_rd), .out_rdata(out_rdata),
    .out_regwr(out_regwr), .out_err(out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic run_op(
    input bit ren, input bit wen,
    input bit [2:0] f3, input bit [31:0] addr,
    input bit [31:0] wdata, input bit [4:0] rd,
    input bit [31:0] word, input bit berr,
    input int d1, input int d2, input int bp);
    int  size, off, nreq, nrsp, lat, k;
    int  e_req, e_rsp, e_lat;
    bit  legal, mis, tmo;
    bit  [31:0] e_addr, e_wd, e_rd, v, m;
    bit  [3:0]  e_st;
    bit  [1:0]  e_err;
    bit         e_wr;

    size  = 1 << f3[1:0];
    off   = addr % 4;
    legal = (ren != wen) &&
            (ren ? (f3 inside {0, 1, 2, 4, 5})
                 : (f3 inside {0, 1, 2}));
    mis   = (addr % size) != 0;
    e_addr = addr - off;
    e_st  = wen ? 4'(((1 << size) - 1) << off) : 4'd0;
    if (size == 1)
      e_wd = (wdata & 32'hFF) * 32'h0101_0101;
    else if (size == 2)
      e_wd = (wdata & 32'hFFFF) * 32'h0001_0001;
    else
      e_wd = wdata;
    tmo = (d1 + d2) >= TMO;
    e_rd = 0;
    e_wr = 0;
    e_req = 0;
    e_rsp = 0;
    if (!legal || mis) begin
      e_err = 2'b01;
      e_lat = 1;
    end else begin
      e_req = (d1 >= TMO) ? TMO : d1 + 1;
      e_rsp = (d1 >= TMO) ? 0
            : tmo ? TMO - d1 : d2 + 1;
      e_lat = e_req + e_rsp + 1;
      if (tmo)
        e_err = 2'b11;
      else if (berr)
        e_err = 2'b10;
      else begin
        e_err = 2'b00;
        if (ren) begin
          e_wr = 1;
          m = (size == 4) ? 32'hFFFF_FFFF
                          : (32'd1 << (8 * size)) - 1;
          v = (word >> (8 * off)) & m;
          if (!f3[2] && size < 4 &&
              v[8 * size - 1])
            v = v | ~m;
          e_rd = v;
        end
      end
    end

    @(negedge clk);
    in_valid  = 1;
    in_ren    = ren;
    in_wen    = wen;
    in_funct3 = f3;
    in_addr   = addr;
    in_wdata  = wdata;
    in_rd     = rd;
    chk("in_ready", 32'(in_ready), 1);
    @(negedge clk);
    in_valid = 0;
    in_ren   = 0;
    in_wen   = 0;
    nreq = 0;
    nrsp = 0;
    lat  = 1;
    while (!out_valid && lat < 40) begin
      k = lat - 1;
      if (req_valid) begin
        nreq++;
        chk("req_addr", req_addr, e_addr);
        chk("req_wen", 32'(req_wen), 32'(wen));
        chk("req_wstrb", 32'(req_wstrb), 32'(e_st));
        if (wen)
          chk("req_wdata", req_wdata, e_wd);
        req_ready = (k >= d1);
      end else
        req_ready = 0;
      if (rsp_ready) begin
        nrsp++;
        rsp_valid = (k >= d1 + 1 + d2);
        rsp_rdata = word;
        rsp_err   = berr;
      end else
        rsp_valid = 0;
      @(negedge clk);
      lat++;
    end
    req_ready = 0;
    rsp_valid = 0;
    chk("out_valid", 32'(out_valid), 1);
    if (!out_valid) return;
    chk("latency", lat, e_lat);
    chk("req_cycles", nreq, e_req);
    chk("rsp_cycles", nrsp, e_rsp);
    for (int i = 0; i <= bp; i++) begin
      chk("hold_valid", 32'(out_valid), 1);
      chk("in_ready_busy", 32'(in_ready), 0);
      chk("out_rd", 32'(out_rd), 32'(rd));
      chk("out_rdata", out_rdata, e_rd);
      chk("out_regwr", 32'(out_regwr), 32'(e_wr));
      chk("out_err", 32'(out_err), 32'(e_err));
      if (i == bp) out_ready = 1;
      @(negedge clk);
    end
    out_ready = 0;
    chk("out_valid_clr", 32'(out_valid), 0);
    chk("out_regwr_clr", 32'(out_regwr), 0);
    chk("in_ready_idle", 32'(in_ready), 1);
  endtask

  initial begin
    int ren, wen, kind;
    rst_n     = 0;
    in_valid  = 0;
    in_ren    = 0;
    in_wen    = 0;
    in_funct3 = 0;
    in_addr   = 0;
    in_wdata  = 0;
    in_rd     = 0;
    req_ready = 0;
    rsp_valid = 0;
    rsp_rdata = 0;
    rsp_err   = 0;
    out_ready = 0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_req_valid", 32'(req_valid), 0);
    chk("rst_rsp_ready", 32'(rsp_ready), 0);
    chk("rst_out_err", 32'(out_err), 0);
    chk("rst_out_rdata", out_rdata, 0);
    chk("rst_out_regwr", 32'(out_regwr), 0);
    chk("rst_req_wstrb", 32'(req_wstrb), 0);
    rst_n = 1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 1);

    run_op(1, 0, 3'b000, 32'h8000_0003, 0, 5,
           32'h80FF_1234, 0, 0, 0, 0);
    run_op(0, 1, 3'b001, 32'h8000_0002,
           32'hDEAD_BEEF, 6, 0, 0, 0, 0, 0);
    run_op(1, 0, 3'b010, 32'h8000_0006, 0, 7,
           0, 0, 0, 0, 0);
    run_op(0, 1, 3'b011, 32'h8000_0000,
           32'h1234_5678, 8, 0, 0, 0, 0, 0);
    run_op(1, 0, 3'b101, 32'h8000_0002, 0, 9,
           32'hABCD_0000, 1, 1, 1, 0);
    run_op(1, 0, 3'b101, 32'h8000_0002, 0, 9,
           32'hABCD_0000, 0, 1, 1, 0);
    run_op(1, 0, 3'b010, 32'h8000_0100, 0, 10,
           32'h1111_2222, 0, 20, 0, 5);
    run_op(1, 1, 3'b000, 32'h8000_0000, 0, 11,
           0, 0, 0, 0, 2);
    run_op(1, 0, 3'b000, 32'h0000_0000, 0, 0,
           32'h0000_007F, 0, 3, 2, 1);

    @(negedge clk);
    in_valid  = 1;
    in_ren    = 1;
    in_funct3 = 3'b010;
    in_addr   = 32'h8000_0010;
    in_rd     = 3;
    @(negedge clk);
    in_valid  = 0;
    in_ren    = 0;
    chk("mid_req_valid", 32'(req_valid), 1);
    req_ready = 1;
    @(negedge clk);
    req_ready = 0;
    chk("mid_rsp_ready", 32'(rsp_ready), 1);
    #1 rst_n = 0;
    #1;
    chk("mid_rst_rsp_ready", 32'(rsp_ready), 0);
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    chk("mid_rst_req_valid", 32'(req_valid), 0);
    @(negedge clk);
    rst_n = 1;
    run_op(0, 1, 3'b010, 32'h8000_0020,
           32'hCAFE_F00D, 12, 0, 0, 1, 0, 0);

    for (int n = 0; n < 120; n++) begin
      kind = $urandom_range(0, 19);
      ren  = (kind < 9) ? 1 : (kind == 18) ? 1 : 0;
      wen  = (kind >= 9 && kind < 18) ? 1
           : (kind == 18) ? 1 : 0;
      run_op(ren[0], wen[0],
             3'($urandom_range(0, 7)),
             32'h8000_0000 | 32'($urandom_range(0, 255)),
             $urandom, 5'($urandom_range(0, 31)),
             $urandom, ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 9) == 0)
               ? $urandom_range(0, 10)
               : $urandom_range(0, 3),
             ($urandom_range(0, 9) == 0)
               ? $urandom_range(0, 10)
               : $urandom_range(0, 3),
             $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
